ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Converts the raw PS/2 byte stream from `PS2_Controller` (`received_data`, `received_data_en`) into decoded key events for the game logic. It handles make, break (`F0`) and extended (`E0`) prefixes, discards the Pause sequence and controller/keyboard status bytes, and buffers events in a small FIFO. It also tracks the held state of the four game keys. Its outputs feed the game control path, replacing the direct `KEY[3]`/`go` hit input.

## Interface
- `TIMEOUT_CYCLES`, default 2_500_000: idle cycles (50 ms at 50 MHz) after which a partial sequence is abandoned.
- `FIFO_DEPTH`, default 4: event FIFO depth; must be a power of two, ≥2.
- `clk`  in  1  system clock (`CLOCK_50`).
- `reset`  in  1  asynchronous, active-high reset.
- `received_data`  in  8  byte from `PS2_Controller`; valid only while `received_data_en` is high.
- `received_data_en`  in  1  one-cycle strobe per received byte.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_data`  out  10  head event: [9] extended, [8] release, [7:0] scancode.
- `evt_ready`  in  1  pop the head event when `evt_valid` is high.
- `key_held`  out  4  held flags: [0] Z `1A`, [1] X `22`, [2] SPACE `29`, [3] ESC `76` (non-extended only).
- `hit_pulse`  out  4  one-cycle pulse on a not-held→held transition of the matching key.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.
- `proto_err`  out  1  one-cycle pulse on an illegal prefix order.

## Operation
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP. Only bytes arriving with `received_data_en` high advance the FSM.
- IDLE:
  - `E0` → GOT_E0.
  - `F0` → GOT_F0.
  - `E1` → SKIP, with skip counter = 7.
  - `AA`/`FA`/`EE`/`FE` are dropped.
  - Any other byte emits {0,0,code}.
- GOT_E0:
  - `F0` → GOT_E0F0.
  - `E0` → stay.
  - Other byte emits {1,0,code} → IDLE.
- GOT_F0: `E0`/`F0`/`E1` pulse `proto_err` and go to IDLE without emitting. Any other byte emits {0,1,code} → IDLE.
- GOT_E0F0: same rule as GOT_F0, but emits {1,1,code}.
- SKIP: each byte decrements the counter; the state returns to IDLE after the 7th byte. No events, held or hit updates are produced.
- Timeout: a cycle counter clears on every byte and counts up in any non-IDLE state. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE silently.
- Held keys:
  - A non-extended make of a game key sets its bit; a non-extended release clears it.
  - `hit_pulse` fires only if the bit was 0, so typematic repeats produce no extra pulses.
  - Held and hit updates are independent of FIFO fullness.
- FIFO:
  - Push when full without a simultaneous pop drops the new event and sets `overflow`.
  - Push and pop in the same cycle while full both succeed.
  - Pop when empty is ignored.

## Timing
- Reset values:
  - FSM IDLE, counters 0, FIFO empty.
  - `evt_valid` 0, `evt_data` 0.
  - `key_held` 0, `hit_pulse` 0, `overflow` 0, `proto_err` 0.
- Decode is combinational from state and byte; all effects register on the edge that samples `received_data_en`. `evt_valid`, `key_held`, `hit_pulse` and `proto_err` therefore change 1 cycle after the strobe.
- `evt_data` is valid whenever `evt_valid` is high. The head advances on the edge where `evt_valid && evt_ready`.
- Back-to-back strobes on consecutive cycles are supported.
- A reset asserted mid-sequence or mid-FIFO takes effect immediately and discards everything.

## Structure
- Package `ps2_key_pkg`:
  - Prefix/status constants `E0`, `F0`, `E1`, `AA`, `FA`, `EE`, `FE`.
  - Game key codes, FSM state encoding, event width 10, Pause skip length 7.
- Sub-module `ps2_event_fifo`: synchronous FIFO with `FIFO_DEPTH`, width 10, and full/empty/overflow logic.
- The FSM, timeout counter and held/hit logic live in the top module.

## Test plan
- Byte `1A` → `evt_data` 0x01A, `key_held[0]`=1, `hit_pulse[0]` high exactly 1 cycle, one cycle after the strobe.
- Bytes `1A 1A 1A F0 1A` → events 0x01A ×3 then 0x11A; a single `hit_pulse[0]`; `key_held[0]` returns to 0.
- `E0 75` then `E0 F0 75` → events 0x275, 0x375; `key_held` unchanged.
- `E1 14 77 E1 F0 14 F0 77 29` → only event 0x029; `hit_pulse[2]` fires.
- `F0`, silence for `TIMEOUT_CYCLES`+1, then `1A` → 0x01A (make, not release). Separately, `F0 E0` → `proto_err` pulse and no event.
- 5 makes with `evt_ready`=0 → 4 events retained in order and `overflow`=1. A push+pop on the same cycle while full keeps the count at 4. `reset` mid-sequence → all outputs return to reset values.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared constants, types and helpers for the PS/2 key decoder.
package ps2_key_pkg;

  // Prefix bytes
  localparam logic [7:0] E0 = 8'hE0;
  localparam logic [7:0] F0 = 8'hF0;
  localparam logic [7:0] E1 = 8'hE1;

  // Controller / keyboard status bytes that never form key events
  localparam logic [7:0] AA = 8'hAA;
  localparam logic [7:0] FA = 8'hFA;
  localparam logic [7:0] EE = 8'hEE;
  localparam logic [7:0] FE = 8'hFE;

  // Game keys (set-2 make codes, non-extended)
  localparam logic [7:0] KeyZ     = 8'h1A;
  localparam logic [7:0] KeyX     = 8'h22;
  localparam logic [7:0] KeySpace = 8'h29;
  localparam logic [7:0] KeyEsc   = 8'h76;

  // Event layout: [9] extended, [8] release, [7:0] scancode
  localparam int unsigned EvtWidth = 10;

  // Bytes that follow E1 in the Pause make sequence
  localparam int unsigned PauseSkipLen = 7;

  typedef enum logic [2:0] {
    StIdle,
    StGotE0,
    StGotF0,
    StGotE0F0,
    StSkip
  } dec_state_e;

  // One-hot position of a game key in key_held / hit_pulse, zero otherwise.
  function automatic logic [3:0] game_key_mask(input logic [7:0] code);
    logic [3:0] mask;
    mask = 4'b0000;
    case (code)
      KeyZ:     mask = 4'b0001;
      KeyX:     mask = 4'b0010;
      KeySpace: mask = 4'b0100;
      KeyEsc:   mask = 4'b1000;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic is_status_byte(input logic [7:0] code);
    return (code == AA) || (code == FA) || (code == EE) || (code == FE);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO for decoded key events with sticky overflow flag.
module ps2_event_fifo
  import ps2_key_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = EvtWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             overflow_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             overflow_q;
  logic             empty, full, do_push, do_pop;

  // Full/empty detection and push/pop qualification
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
              (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    do_pop  = pop_i && !empty;
    // A pop in the same cycle frees the slot the push needs
    do_push = push_i && (!full || do_pop);
  end

  // Pointer and sticky overflow state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !do_push) overflow_q <= 1'b1;
    end
  end

  // Storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
  end

  // Head of queue, forced to zero while empty
  always_comb begin
    valid_o    = !empty;
    data_o     = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
    overflow_o = overflow_q;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns the raw PS/2 byte stream into make/break key events and game-key held/hit flags.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic                evt_valid,
  output logic [EvtWidth-1:0] evt_data,
  input  logic                evt_ready,
  output logic [3:0]          key_held,
  output logic [3:0]          hit_pulse,
  output logic                overflow,
  output logic                proto_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  dec_state_e          state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [3:0]          held_q, held_d;
  logic [3:0]          hit_q, hit_d;
  logic                perr_q, perr_d;
  logic                emit;
  logic [EvtWidth-1:0] emit_data;
  logic [3:0]          key_mask;
  logic                is_prefix;

  // Byte decode, prefix FSM, timeout and held/hit next-state
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    tmo_d     = tmo_q;
    perr_d    = 1'b0;
    emit      = 1'b0;
    emit_data = '0;
    is_prefix = (received_data == E0) || (received_data == F0) || (received_data == E1);

    if (received_data_en) begin
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (received_data == E0) begin
            state_d = StGotE0;
          end else if (received_data == F0) begin
            state_d = StGotF0;
          end else if (received_data == E1) begin
            state_d = StSkip;
            skip_d  = 3'(PauseSkipLen);
          end else if (!is_status_byte(received_data)) begin
            emit      = 1'b1;
            emit_data = {1'b0, 1'b0, received_data};
          end
        end
        StGotE0: begin
          if (received_data == F0) begin
            state_d = StGotE0F0;
          end else if (received_data != E0) begin
            emit      = 1'b1;
            emit_data = {1'b1, 1'b0, received_data};
            state_d   = StIdle;
          end
        end
        StGotF0, StGotE0F0: begin
          state_d = StIdle;
          if (is_prefix) begin
            perr_d = 1'b1;
          end else begin
            emit      = 1'b1;
            emit_data = {(state_q == StGotE0F0), 1'b1, received_data};
          end
        end
        StSkip: begin
          if (skip_q <= 3'd1) begin
            skip_d  = '0;
            state_d = StIdle;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // Abandon a stalled partial sequence without any side effect
      if (tmo_q >= TmoLast) begin
        state_d = StIdle;
        skip_d  = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end

    // Only non-extended events touch the game keys; FIFO fullness is irrelevant here
    held_d   = held_q;
    hit_d    = '0;
    key_mask = game_key_mask(emit_data[7:0]);
    if (emit && !emit_data[9]) begin
      if (emit_data[8]) begin
        held_d = held_q & ~key_mask;
      end else begin
        held_d = held_q | key_mask;
        hit_d  = key_mask & ~held_q;
      end
    end
  end

  // Decoder state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      skip_q  <= '0;
      tmo_q   <= '0;
      held_q  <= '0;
      hit_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      held_q  <= held_d;
      hit_q   <= hit_d;
      perr_q  <= perr_d;
    end
  end

  ps2_event_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EvtWidth)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (emit),
    .push_data_i (emit_data),
    .pop_i       (evt_ready),
    .valid_o     (evt_valid),
    .data_o      (evt_data),
    .overflow_o  (overflow)
  );

  // Registered status outputs
  always_comb begin
    key_held  = held_q;
    hit_pulse = hit_q;
    proto_err = perr_q;
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder.
module tb_ps2_key_decoder;

  localparam int unsigned Tmo   = 20;
  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [9:0] evt_data;
  logic [3:0] key_held;
  logic [3:0] hit_pulse;
  logic       overflow;
  logic       proto_err;

  int n_checks = 0;
  int n_fails  = 0;
  int hit0_total = 0;
  int hit2_total = 0;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES (Tmo),
    .FIFO_DEPTH     (Depth)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .evt_valid        (evt_valid),
    .evt_data         (evt_data),
    .evt_ready        (evt_ready),
    .key_held         (key_held),
    .hit_pulse        (hit_pulse),
    .overflow         (overflow),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;

  // Running tally of hit pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (hit_pulse[0]) hit0_total++;
    if (hit_pulse[2]) hit2_total++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One strobed byte; returns at the negedge where its effects are visible
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
    received_data    = 8'h00;
  endtask

  // Capture the head at a negedge and pop it
  task automatic pop_event(output logic v, output logic [9:0] d);
    v = evt_valid;
    d = evt_data;
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({evt_valid, evt_data, key_held, hit_pulse, overflow, proto_err} !== 20'h0) begin
      $display("FAIL reset_state: got valid=%b data=%h held=%b hit=%b ovf=%b perr=%b, want all 0",
               evt_valid, evt_data, key_held, hit_pulse, overflow, proto_err);
      n_fails++;
    end
  endtask

  task automatic test_make();
    int h0;
    logic v;
    logic [9:0] d;
    do_reset();
    h0 = hit0_total;
    send_byte(8'h1A);
    n_checks++;
    if ({evt_valid, evt_data} !== {1'b1, 10'h01A}) begin
      $display("FAIL make_event: got valid=%b data=%h, want 1/01a", evt_valid, evt_data);
      n_fails++;
    end
    n_checks++;
    if ({key_held, hit_pulse} !== 8'b0001_0001) begin
      $display("FAIL make_held_hit: got held=%b hit=%b, want 0001/0001", key_held, hit_pulse);
      n_fails++;
    end
    @(negedge clk);
    n_checks++;
    if ({key_held, hit_pulse} !== 8'b0001_0000) begin
      $display("FAIL make_hit_end: got held=%b hit=%b, want 0001/0000", key_held, hit_pulse);
      n_fails++;
    end
    @(negedge clk);
    n_checks++;
    if (hit0_total - h0 != 1) begin
      $display("FAIL make_hit_count: got %0d pulses, want 1", hit0_total - h0);
      n_fails++;
    end
    pop_event(v, d);
    n_checks++;
    if ({v, d, evt_valid} !== {1'b1, 10'h01A, 1'b0}) begin
      $display("FAIL make_pop: got v=%b d=%h after=%b, want 1/01a/0", v, d, evt_valid);
      n_fails++;
    end
  endtask

  task automatic test_typematic();
    int h0;
    logic v;
    logic [9:0] d;
    logic [9:0] exp_evt [4];
    exp_evt = '{10'h01A, 10'h01A, 10'h01A, 10'h11A};
    do_reset();
    h0 = hit0_total;
    send_byte(8'h1A);
    send_byte(8'h1A);
    send_byte(8'h1A);
    send_byte(8'hF0);
    send_byte(8'h1A);
    repeat (2) @(negedge clk);
    n_checks++;
    if (hit0_total - h0 != 1) begin
      $display("FAIL typematic_hits: got %0d pulses, want 1", hit0_total - h0);
      n_fails++;
    end
    n_checks++;
    if (key_held !== 4'b0000) begin
      $display("FAIL typematic_held: got %b, want 0000", key_held);
      n_fails++;
    end
    for (int i = 0; i < 4; i++) begin
      pop_event(v, d);
      n_checks++;
      if ({v, d} !== {1'b1, exp_evt[i]}) begin
        $display("FAIL typematic_evt%0d: got v=%b d=%h, want 1/%h", i, v, d, exp_evt[i]);
        n_fails++;
      end
    end
  endtask

  task automatic test_extended();
    logic v;
    logic [9:0] d;
    logic [9:0] exp_evt [3];
    exp_evt = '{10'h275, 10'h375, 10'h21A};
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    // Extended code sharing a game-key scancode must not count as held
    send_byte(8'hE0);
    send_byte(8'h1A);
    n_checks++;
    if ({key_held, hit_pulse} !== 8'h00) begin
      $display("FAIL ext_held: got held=%b hit=%b, want 0000/0000", key_held, hit_pulse);
      n_fails++;
    end
    for (int i = 0; i < 3; i++) begin
      pop_event(v, d);
      n_checks++;
      if ({v, d} !== {1'b1, exp_evt[i]}) begin
        $display("FAIL ext_evt%0d: got v=%b d=%h, want 1/%h", i, v, d, exp_evt[i]);
        n_fails++;
      end
    end
  endtask

  task automatic test_pause();
    int h2;
    logic v;
    logic [9:0] d;
    logic [7:0] seq [9];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
    do_reset();
    h2 = hit2_total;
    for (int i = 0; i < 9; i++) send_byte(seq[i]);
    repeat (2) @(negedge clk);
    n_checks++;
    if (hit2_total - h2 != 1 || key_held !== 4'b0100) begin
      $display("FAIL pause_space: got hits=%0d held=%b, want 1/0100", hit2_total - h2, key_held);
      n_fails++;
    end
    pop_event(v, d);
    n_checks++;
    if ({v, d, evt_valid} !== {1'b1, 10'h029, 1'b0}) begin
      $display("FAIL pause_evt: got v=%b d=%h after=%b, want 1/029/0", v, d, evt_valid);
      n_fails++;
    end
  endtask

  task automatic test_timeout();
    logic v;
    logic [9:0] d;
    do_reset();
    send_byte(8'hF0);
    repeat (Tmo + 1) @(negedge clk);
    send_byte(8'h1A);
    // A short gap keeps the release prefix alive
    send_byte(8'hF0);
    repeat (5) @(negedge clk);
    send_byte(8'h1A);
    pop_event(v, d);
    n_checks++;
    if ({v, d} !== {1'b1, 10'h01A}) begin
      $display("FAIL timeout_make: got v=%b d=%h, want 1/01a", v, d);
      n_fails++;
    end
    pop_event(v, d);
    n_checks++;
    if ({v, d, key_held} !== {1'b1, 10'h11A, 4'b0000}) begin
      $display("FAIL short_gap_release: got v=%b d=%h held=%b, want 1/11a/0000", v, d, key_held);
      n_fails++;
    end
  endtask

  task automatic test_proto_err();
    logic v;
    logic [9:0] d;
    do_reset();
    send_byte(8'hF0);
    send_byte(8'hE0);
    n_checks++;
    if ({proto_err, evt_valid} !== 2'b10) begin
      $display("FAIL proto_pulse: got perr=%b valid=%b, want 1/0", proto_err, evt_valid);
      n_fails++;
    end
    @(negedge clk);
    n_checks++;
    if (proto_err !== 1'b0) begin
      $display("FAIL proto_width: got perr=%b, want 0", proto_err);
      n_fails++;
    end
    send_byte(8'hAA);
    send_byte(8'hFA);
    send_byte(8'hEE);
    send_byte(8'hFE);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      $display("FAIL status_drop: got valid=%b, want 0", evt_valid);
      n_fails++;
    end
    send_byte(8'h1A);
    pop_event(v, d);
    n_checks++;
    if ({v, d} !== {1'b1, 10'h01A}) begin
      $display("FAIL proto_recover: got v=%b d=%h, want 1/01a", v, d);
      n_fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic v;
    logic [9:0] d;
    logic [7:0] seq [4];
    seq = '{8'hE0, 8'hF0, 8'h75, 8'h22};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      received_data    = seq[i];
      received_data_en = 1'b1;
    end
    @(negedge clk);
    received_data_en = 1'b0;
    pop_event(v, d);
    n_checks++;
    if ({v, d} !== {1'b1, 10'h375}) begin
      $display("FAIL b2b_evt0: got v=%b d=%h, want 1/375", v, d);
      n_fails++;
    end
    pop_event(v, d);
    n_checks++;
    if ({v, d, key_held} !== {1'b1, 10'h022, 4'b0010}) begin
      $display("FAIL b2b_evt1: got v=%b d=%h held=%b, want 1/022/0010", v, d, key_held);
      n_fails++;
    end
  endtask

  task automatic test_overflow();
    logic v;
    logic [9:0] d;
    logic [9:0] exp_evt [4];
    exp_evt = '{10'h01A, 10'h022, 10'h029, 10'h04D};
    do_reset();
    send_byte(8'h15);
    send_byte(8'h1A);
    send_byte(8'h22);
    send_byte(8'h29);
    n_checks++;
    if ({evt_valid, overflow} !== 2'b10) begin
      $display("FAIL ovf_at_full: got valid=%b ovf=%b, want 1/0", evt_valid, overflow);
      n_fails++;
    end
    send_byte(8'h76);
    n_checks++;
    if ({overflow, key_held} !== {1'b1, 4'b1111}) begin
      $display("FAIL ovf_set: got ovf=%b held=%b, want 1/1111", overflow, key_held);
      n_fails++;
    end
    // Simultaneous push and pop while full
    @(negedge clk);
    received_data    = 8'h4D;
    received_data_en = 1'b1;
    evt_ready        = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
    evt_ready        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pop_event(v, d);
      n_checks++;
      if ({v, d} !== {1'b1, exp_evt[i]}) begin
        $display("FAIL ovf_evt%0d: got v=%b d=%h, want 1/%h", i, v, d, exp_evt[i]);
        n_fails++;
      end
    end
    n_checks++;
    if ({evt_valid, overflow} !== 2'b01) begin
      $display("FAIL ovf_drain: got valid=%b ovf=%b, want 0/1", evt_valid, overflow);
      n_fails++;
    end
  endtask

  task automatic test_reset_mid();
    logic v;
    logic [9:0] d;
    do_reset();
    send_byte(8'h1A);
    send_byte(8'h22);
    send_byte(8'h29);
    send_byte(8'h76);
    send_byte(8'h15);
    send_byte(8'hE0);
    send_byte(8'hF0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({evt_valid, evt_data, key_held, hit_pulse, overflow, proto_err} !== 20'h0) begin
      $display("FAIL reset_mid: got valid=%b data=%h held=%b hit=%b ovf=%b perr=%b, want all 0",
               evt_valid, evt_data, key_held, hit_pulse, overflow, proto_err);
      n_fails++;
    end
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h75);
    pop_event(v, d);
    n_checks++;
    if ({v, d} !== {1'b1, 10'h075}) begin
      $display("FAIL reset_mid_state: got v=%b d=%h, want 1/075", v, d);
      n_fails++;
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_typematic();
    test_extended();
    test_pause();
    test_timeout();
    test_proto_err();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
